cpu_memory: RTL
===============

Name: cpu_memory

Overview:
- Memory responder on the other end of the CPU memory port. The CPU drives mem_we, mem_addr and mem_data; this block returns read data on mem_in.
- Holds 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Has a bring-up sequencer that zero-clears the array after reset, then accepts a program image through a loader port, then serves the CPU.
- ready is used at top level to hold the CPU in reset until the block is serving.

Parameters:
ADDR_WIDTH, 6, address width; depth = 2^ADDR_WIDTH words
DATA_WIDTH, 16, word width
CLEAR_ON_RESET, 1, 1 = zero-sweep the array after reset; 0 = go straight to LOAD

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
we  input  1  CPU write enable (connects to CPU mem_we)
addr  input  ADDR_WIDTH  CPU address (CPU mem_addr)
data  input  DATA_WIDTH  CPU write data (CPU mem_data)
out  output  DATA_WIDTH  read data to CPU (CPU mem_in)
ready  output  1  high only in RUN
ld_valid  input  1  loader write request
ld_addr  input  ADDR_WIDTH  loader address
ld_data  input  DATA_WIDTH  loader data
ld_done  input  1  loader finished; leave LOAD
ld_ready  output  1  high only in LOAD
prot_err  output  1  sticky protection violation (optional feature only; otherwise tied 0)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state = CLEAR (or LOAD if CLEAR_ON_RESET=0), clear pointer = 0, out = 0, ready = 0, ld_ready = 0, prot_err = 0.
- Reset does not touch array contents directly.
- rst asserted mid-sweep, mid-load or in RUN aborts the activity; the sequence restarts from the reset state once rst deasserts.

FSM states: CLEAR, LOAD, RUN.

CLEAR:
- Each cycle writes 0 to mem[ptr], then increments ptr.
- On the cycle ptr = 2^ADDR_WIDTH-1 is written, go to LOAD.
- Exactly 2^ADDR_WIDTH cycles (64 at default).
- CPU and loader inputs are ignored; out holds 0.

LOAD:
- ld_ready = 1.
- ld_valid = 1: mem[ld_addr] <= ld_data at the clock edge.
- ld_done = 1: go to RUN on the next edge.
- ld_valid and ld_done in the same cycle: the write is performed, then go to RUN.
- CPU inputs are ignored.

RUN:
- ready = 1. Loader inputs are ignored; RUN is terminal until reset.
- Read (we = 0): out <= mem[addr] at the edge. Latency is 1 cycle: address presented in cycle N, data valid in cycle N+1.
- Write (we = 1): mem[addr] <= data and out <= data (write-through) in the same edge.
- A read of an address written in the previous cycle returns the new data.
- out only changes on a RUN edge; it holds its value in all other cases.

Widths and boundaries:
- Addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case.
- Address 2^ADDR_WIDTH-1 (63, the stack top) is legal for both ports.
- No arithmetic on data; words are stored verbatim.

Optional Feature:
Macro: CPU_MEMORY_WRITE_PROTECT_EN
- Defined:
  - In RUN, CPU writes to addresses 0..7 (the region below the first instruction at 8) are suppressed: the array is unchanged and out <= the current mem[addr].
  - prot_err is set to 1 and stays set until rst.
  - Loader and CLEAR writes to 0..7 remain permitted.
- Not defined:
  - All CPU writes are performed.
  - prot_err is constant 0.

Test Plan:
- Reset then release, CLEAR_ON_RESET=1 -> ready = 0 and ld_ready = 0 for 64 cycles; ld_ready = 1 on cycle 65. A read in RUN of any unloaded address returns 0x0000.
- LOAD: write 0x1234 to 8 and 0xF000 to 9, with ld_done in the same cycle as the last write -> ready rises the next cycle. Reads of 8 and 9 return 0x1234 and 0xF000 one cycle after the address is presented.
- RUN: write 0xBEEF to 63, then read 63 on the next cycle -> out = 0xBEEF on the write edge and again after the read.
- Assert rst at cycle 30 of CLEAR, then release -> the full 64-cycle sweep restarts. Words loaded earlier read back as 0.
- RUN: we = 0 with the address changing every cycle (8, 9, 10) -> out follows one cycle behind. With we = 0 and addr held, out is stable.
- CPU_MEMORY_WRITE_PROTECT_EN defined, loader puts 0x0055 at 3, then CPU writes 0xAAAA to 3 -> mem[3] stays 0x0055, out = 0x0055, and prot_err = 1 until rst. Without the macro, mem[3] = 0xAAAA and prot_err = 0.

Source files
------------

// File: rtl/cpu_memory.sv
`default_nettype none
// ============================================================================
// Module   : cpu_memory
// Brief    : CPU-side memory responder with a bring-up sequencer.
//            CLEAR zero-sweeps the array, LOAD accepts a program image from
//            the loader port, RUN serves CPU reads/writes with 1-cycle read
//            latency and write-through on out.
//            Optional feature macro: CPU_MEMORY_WRITE_PROTECT_EN
//            (suppresses CPU writes to addresses 0..7 in RUN, sticky prot_err).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_memory #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ready,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_done,
    output logic                  ld_ready,
    output logic                  prot_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = '1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_LOAD;

`ifdef CPU_MEMORY_WRITE_PROTECT_EN
    // First instruction lives at 8; everything below it is CPU read-only.
    localparam logic [ADDR_WIDTH-1:0] c_PROT_LIMIT = ADDR_WIDTH'(8);
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  ready_q;
    logic                  ld_ready_q;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  prot_hit;
    logic [DATA_WIDTH-1:0] rd_data;

    // Old array contents at the CPU address; a write in the previous cycle
    // has already landed, so back-to-back write/read sees the new word.
    assign rd_data = mem_q[addr];

    // Single write port shared by the sweep, the loader and the CPU.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        prot_hit = 1'b0;
        case (state_q)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
            end
            S_LOAD: begin
                wr_en   = ld_valid;
                wr_addr = ld_addr;
                wr_data = ld_data;
            end
            S_RUN: begin
`ifdef CPU_MEMORY_WRITE_PROTECT_EN
                prot_hit = we && (addr < c_PROT_LIMIT);
`endif
                wr_en   = we && !prot_hit;
                wr_addr = addr;
                wr_data = data;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Storage array: not reset, only written through the shared port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef CPU_MEMORY_WRITE_PROTECT_EN
    logic prot_err_q;

    // Sticky protection flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prot_err_q <= 1'b0;
        end else if (prot_hit) begin
            prot_err_q <= 1'b1;
        end
    end

    assign prot_err = prot_err_q;
`else
    assign prot_err = 1'b0;
`endif

    // Bring-up sequencer with registered handshake outputs and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_RESET_STATE;
            ptr_q      <= '0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == c_PTR_LAST) begin
                        state_q    <= S_LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Also raises ld_ready one edge after reset when the
                    // sweep is skipped and LOAD is the reset state.
                    ld_ready_q <= 1'b1;
                    if (ld_done) begin
                        state_q    <= S_RUN;
                        ld_ready_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q    <= 1'b1;
                    ld_ready_q <= 1'b0;
                    if (we && !prot_hit) begin
                        out_q <= data;
                    end else begin
                        out_q <= rd_data;
                    end
                end
                default: begin
                    state_q    <= c_RESET_STATE;
                    ready_q    <= 1'b0;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign out      = out_q;
    assign ready    = ready_q;
    assign ld_ready = ld_ready_q;

endmodule
`default_nettype wire
